// File: rtl/alu_sweep_controller.sv
// ---------------------------------------------------------------------------
// alu_sweep_controller
//
// Sequencer that sits in front of boolean_alu. When start is seen in IDLE it
// latches one operand pair, presents it to the ALU and walks the select code
// through every ALU operation. Each select code is held for HOLD cycles so the
// ALU output can settle. The result is then captured and offered downstream
// on a valid/ready port. A rotate-XOR signature over every accepted result is
// kept so the whole sweep can be verified against a single golden value.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 begin a sweep (only looked at while idle)
//   op_a, op_b            operand pair, latched when start is accepted
//   alu_in1, alu_in2      registered operands driven to the ALU
//   alu_select            registered select code driven to the ALU
//   alu_out               ALU result coming back
//   res_valid, res_ready  downstream handshake
//   res_data, res_sel     captured ALU result and the select that produced it
//   busy                  high whenever a sweep is in progress
//   done                  one-cycle pulse once the last result is accepted
//   signature             running rotate-XOR signature of accepted results
// ---------------------------------------------------------------------------
module alu_sweep_controller #(
  parameter int DATA_W = 4,
  parameter int RES_W  = DATA_W + 1,
  parameter int SEL_W  = 3,
  parameter int HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [SEL_W-1:0]  alu_select,
  input  logic [RES_W-1:0]  alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [SEL_W-1:0]  res_sel,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  signature
);

  localparam int NUM_OPS = 2 ** SEL_W;
  localparam int CNT_W   = $clog2(HOLD + 1);

  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_OUT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [SEL_W-1:0]  alu_select_q, alu_select_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [SEL_W-1:0]  res_sel_q, res_sel_d;
  logic [RES_W-1:0]  signature_q, signature_d;

  // State and datapath registers. Everything clears on reset so the outputs
  // read zero as soon as rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_select_q <= '0;
      hold_cnt_q   <= '0;
      res_data_q   <= '0;
      res_sel_q    <= '0;
      signature_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_select_q <= alu_select_d;
      hold_cnt_q   <= hold_cnt_d;
      res_data_q   <= res_data_d;
      res_sel_q    <= res_sel_d;
      signature_q  <= signature_d;
    end
  end

  // Next-state and datapath update. Registers hold by default, which keeps
  // the operands, select and captured result stable while downstream stalls
  // and keeps the operands and signature visible in IDLE after a sweep.
  always_comb begin
    state_d      = state_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_select_d = alu_select_q;
    hold_cnt_d   = hold_cnt_q;
    res_data_d   = res_data_q;
    res_sel_d    = res_sel_q;
    signature_d  = signature_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alu_in1_d    = op_a;
          alu_in2_d    = op_b;
          alu_select_d = '0;
          hold_cnt_d   = '0;
          signature_d  = '0;
          state_d      = S_DRIVE;
        end
      end

      S_DRIVE: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        // Sample only on the last cycle of the settle window so transient
        // ALU output right after a select change is never captured.
        if (hold_cnt_q == HOLD_LAST) begin
          res_data_d = alu_out;
          res_sel_d  = alu_select_q;
          state_d    = S_OUT;
        end
      end

      S_OUT: begin
        // res_ready only matters here; elsewhere res_valid is low.
        if (res_ready) begin
          signature_d = {signature_q[RES_W-2:0], signature_q[RES_W-1]} ^ res_data_q;
          if (alu_select_q == LAST_SEL) begin
            state_d = S_DONE;
          end else begin
            alu_select_d = alu_select_q + SEL_W'(1);
            hold_cnt_d   = '0;
            state_d      = S_DRIVE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore status outputs decoded from the current state.
  always_comb begin
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE:  busy      = 1'b0;
      S_DRIVE: res_valid = 1'b0;
      S_OUT:   res_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_select = alu_select_q;
  assign res_data   = res_data_q;
  assign res_sel    = res_sel_q;
  assign signature  = signature_q;

endmodule

// File: tb/tb_alu_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_alu_sweep_controller
//
// Self-checking bench for alu_sweep_controller. Two instances are used: the
// main one with HOLD=2 and a second with HOLD=1 that shows the effect of a
// shorter settle window. Each ALU is replaced by a stub that returns the
// select code, optionally with a 5'h1F glitch during the first cycle after the
// operands or select change. Expected results, timing and signatures come from
// a small reference model of the sweep rules.
// ---------------------------------------------------------------------------
module tb_alu_sweep_controller;

  logic       clk;
  logic       rst_n;

  // Main instance, HOLD = 2
  logic       start;
  logic [3:0] op_a, op_b;
  logic [3:0] alu_in1, alu_in2;
  logic [2:0] alu_select;
  logic [4:0] alu_out;
  logic       res_valid, res_ready;
  logic [4:0] res_data;
  logic [2:0] res_sel;
  logic       busy, done;
  logic [4:0] signature;

  // Second instance, HOLD = 1
  logic       start1;
  logic [3:0] alu_in1_1, alu_in2_1;
  logic [2:0] alu_select1;
  logic [4:0] alu_out1;
  logic       res_valid1;
  logic [4:0] res_data1;
  logic [2:0] res_sel1;
  logic       busy1, done1;
  logic [4:0] signature1;

  logic       glitch_mode;
  logic [2:0] prev_sel0, prev_sel1;
  logic       prev_busy0, prev_busy1;

  int checks = 0;
  int errors = 0;

  alu_sweep_controller #(.DATA_W(4), .RES_W(5), .SEL_W(3), .HOLD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_select(alu_select),
    .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sel(res_sel), .busy(busy), .done(done),
    .signature(signature)
  );

  alu_sweep_controller #(.DATA_W(4), .RES_W(5), .SEL_W(3), .HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
    .alu_in1(alu_in1_1), .alu_in2(alu_in2_1), .alu_select(alu_select1),
    .alu_out(alu_out1), .res_valid(res_valid1), .res_ready(1'b1),
    .res_data(res_data1), .res_sel(res_sel1), .busy(busy1), .done(done1),
    .signature(signature1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stubs: remember last cycle's select/busy so a freshly changed input
  // can be made to show an unsettled 5'h1F for one cycle.
  always @(posedge clk) begin
    prev_sel0  <= alu_select;
    prev_busy0 <= busy;
    prev_sel1  <= alu_select1;
    prev_busy1 <= busy1;
  end

  assign alu_out  = (glitch_mode && busy && (!prev_busy0 || alu_select != prev_sel0))
                    ? 5'h1F : {2'b00, alu_select};
  assign alu_out1 = (glitch_mode && busy1 && (!prev_busy1 || alu_select1 != prev_sel1))
                    ? 5'h1F : {2'b00, alu_select1};

  function automatic logic [4:0] rotx(input logic [4:0] s, input logic [4:0] d);
    return {s[3:0], s[4]} ^ d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One sweep on the main instance. exact=1 checks cycle timing with
  // res_ready held high; otherwise res_ready is random (ready_pct) with an
  // optional five-cycle stall on stall_op. inject_n >= 0 pulses start with a
  // different op_a after that edge count to show it is ignored while busy.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit exact,
                               input int ready_pct, input int stall_op, input int inject_n);
    logic [4:0] sig_m;
    logic [4:0] exp_d;
    int k, n, dones, post, stalls;
    bit fin;
    op_a = a; op_b = b; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sig_m = '0; k = 0; n = 0; dones = 0; post = 0; stalls = 0; fin = 1'b0;
    while (!fin) begin
      exp_d = 5'(k);
      if (exact) begin
        checkOutput("res_valid_timing", 32'(res_valid), 32'(n < 24 && n % 3 == 2));
        checkOutput("done_timing", 32'(done), 32'(n == 24));
        checkOutput("busy_timing", 32'(busy), 32'(n <= 24));
      end
      if (res_valid) begin
        checkOutput("res_sel", 32'(res_sel), 32'(k));
        checkOutput("res_data", 32'(res_data), 32'(exp_d));
        checkOutput("alu_select_hold", 32'(alu_select), 32'(k));
        checkOutput("alu_in1", 32'(alu_in1), 32'(a));
        checkOutput("alu_in2", 32'(alu_in2), 32'(b));
        checkOutput("signature_running", 32'(signature), 32'(sig_m));
      end
      if (done) begin
        dones++;
        checkOutput("results_at_done", 32'(k), 32'd8);
        checkOutput("signature_at_done", 32'(signature), 32'(sig_m));
        checkOutput("busy_in_done", 32'(busy), 32'd1);
      end
      if (dones > 0 && !done) begin
        post++;
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("signature_held", 32'(signature), 32'(sig_m));
        checkOutput("alu_in1_held", 32'(alu_in1), 32'(a));
        if (post == 4) fin = 1'b1;
      end
      if (exact) begin
        res_ready = 1'b1;
      end else if (res_valid && k == stall_op && stalls < 5) begin
        res_ready = 1'b0;
        stalls++;
      end else begin
        res_ready = (int'($urandom_range(99)) < ready_pct);
      end
      if (n == inject_n) begin
        start = 1'b1; op_a = 4'hF;
      end else begin
        start = 1'b0; op_a = a;
      end
      if (res_valid && res_ready) begin
        sig_m = rotx(sig_m, exp_d);
        k++;
      end
      if (n > 400) begin
        checkOutput("sweep_timeout", 32'd1, 32'd0);
        fin = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; op_a = a; res_ready = 1'b1;
    checkOutput("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [4:0] sig_m;
    int k, n;

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; op_a = '0; op_b = '0;
    res_ready = 1'b1; glitch_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_alu_select", 32'(alu_select), 32'd0);
    checkOutput("rst_signature", 32'(signature), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal sweep
    $display("[TB] nominal sweep");
    applyStimulus(4'b1010, 4'b0101, 1'b1, 100, -1, -1);
    checkOutput("nominal_signature", 32'(signature), 32'h0F);

    // Random operands, exact timing
    for (int i = 0; i < 3; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      applyStimulus(ra, rb, 1'b1, 100, -1, -1);
    end

    // Directed backpressure on op 3
    $display("[TB] backpressure on op 3");
    applyStimulus(4'b1010, 4'b0101, 1'b0, 100, 3, -1);
    checkOutput("backpressure_signature", 32'(signature), 32'h0F);

    // Random backpressure
    for (int i = 0; i < 3; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      applyStimulus(ra, rb, 1'b0, 50, -1, -1);
    end

    // Start while busy
    $display("[TB] start while busy");
    applyStimulus(4'b1010, 4'b0101, 1'b1, 100, -1, 10);

    // Settle window with glitching ALU
    $display("[TB] settle window");
    glitch_mode = 1'b1;
    applyStimulus(4'h3, 4'hC, 1'b1, 100, -1, -1);
    checkOutput("settle_hold2_signature", 32'(signature), 32'h0F);

    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    sig_m = '0; k = 0; n = 0;
    while (n <= 17) begin
      checkOutput("h1_valid_timing", 32'(res_valid1), 32'(n < 16 && n % 2 == 1));
      checkOutput("h1_done_timing", 32'(done1), 32'(n == 16));
      checkOutput("h1_busy_timing", 32'(busy1), 32'(n <= 16));
      if (res_valid1) begin
        checkOutput("h1_res_data", 32'(res_data1), 32'h1F);
        checkOutput("h1_res_sel", 32'(res_sel1), 32'(k));
        sig_m = rotx(sig_m, 5'h1F);
        k++;
      end
      if (done1) checkOutput("h1_signature", 32'(signature1), 32'(sig_m));
      @(negedge clk);
      n++;
    end
    checkOutput("h1_result_count", 32'(k), 32'd8);
    glitch_mode = 1'b0;

    // Reset in the middle of op 4
    $display("[TB] reset mid-op");
    op_a = 4'b1010; op_b = 4'b0101; res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(res_valid && res_sel == 3'd4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_op4_edge", 32'(n), 32'd14);
    res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_alu_in1", 32'(alu_in1), 32'd0);
    checkOutput("mid_rst_alu_in2", 32'(alu_in2), 32'd0);
    checkOutput("mid_rst_alu_select", 32'(alu_select), 32'd0);
    checkOutput("mid_rst_res_data", 32'(res_data), 32'd0);
    checkOutput("mid_rst_res_sel", 32'(res_sel), 32'd0);
    checkOutput("mid_rst_signature", 32'(signature), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 100, -1, -1);
    checkOutput("post_reset_signature", 32'(signature), 32'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
